// File: rtl/frame_motion_detector.sv
// Frame-store read address generator plus per-pixel grayscale motion detector
// with per-frame motion count and bounding box, in the VGA pixel-clock domain.
module frame_motion_detector #(
  parameter int unsigned SRC_W       = 160,
  parameter int unsigned SRC_H       = 120,
  parameter int unsigned SCALE_SHIFT = 2,
  parameter int unsigned MIN_PIXELS  = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        de,
  input  logic [9:0]  x_pixel,
  input  logic [9:0]  y_pixel,
  input  logic [7:0]  thresh,
  output logic        oe,
  output logic [14:0] rAddr,
  input  logic [15:0] prev_data,
  input  logic [15:0] curr_data,
  output logic        motion_px,
  output logic        motion_de,
  output logic        stats_valid,
  output logic [14:0] motion_count,
  output logic [7:0]  box_x_min,
  output logic [7:0]  box_x_max,
  output logic [6:0]  box_y_min,
  output logic [6:0]  box_y_max,
  output logic        motion_found
);

  localparam logic [9:0]  LAST_X   = 10'((SRC_W << SCALE_SHIFT) - 1);
  localparam logic [9:0]  LAST_Y   = 10'((SRC_H << SCALE_SHIFT) - 1);
  localparam logic [9:0]  SUB_MASK = 10'((1 << SCALE_SHIFT) - 1);
  localparam logic [14:0] CNT_MAX  = 15'(SRC_W * SRC_H);
  localparam logic [14:0] MIN_CNT  = 15'(MIN_PIXELS);

  typedef struct packed {
    logic       de;
    logic       tag;
    logic       first;
    logic       last;
    logic [7:0] sx;
    logic [6:0] sy;
  } sb_t;

  function automatic logic [7:0] gray8(input logic [15:0] p);
    return {2'b00, p[15:11], 1'b0} + {2'b00, p[10:5]} + {2'b00, p[4:0], 1'b0};
  endfunction

  sb_t         w_sb0;
  sb_t         r_sb [4];
  logic [14:0] r_addr;
  logic [7:0]  r_gray_p, r_gray_c;
  logic [7:0]  w_diff;
  logic        r_motion;

  logic        r_armed;
  logic [14:0] r_cnt, w_cnt_nx;
  logic [7:0]  r_xmin, r_xmax, w_xmin_nx, w_xmax_nx;
  logic [6:0]  r_ymin, r_ymax, w_ymin_nx, w_ymax_nx;
  logic        w_hit;

  logic        r_stats_valid, r_found;
  logic [14:0] r_motion_count;
  logic [7:0]  r_box_x_min, r_box_x_max;
  logic [6:0]  r_box_y_min, r_box_y_max;

  always_comb begin
    w_sb0       = '0;
    w_sb0.de    = de;
    w_sb0.tag   = ((x_pixel & SUB_MASK) == '0) && ((y_pixel & SUB_MASK) == '0);
    w_sb0.first = de && (x_pixel == '0) && (y_pixel == '0);
    w_sb0.last  = de && (x_pixel == LAST_X) && (y_pixel == LAST_Y);
    w_sb0.sx    = 8'(x_pixel >> SCALE_SHIFT);
    w_sb0.sy    = 7'(y_pixel >> SCALE_SHIFT);
  end

  assign w_diff = (r_gray_c >= r_gray_p) ? (r_gray_c - r_gray_p) : (r_gray_p - r_gray_c);

  // Stage k of the side-band lives in r_sb[k-1]; gray regs align with r_sb[2].
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < 4; i++) r_sb[i] <= '0;
      r_addr   <= '0;
      r_gray_p <= '0;
      r_gray_c <= '0;
      r_motion <= 1'b0;
    end else begin
      r_sb[0] <= w_sb0;
      for (int unsigned i = 1; i < 4; i++) r_sb[i] <= r_sb[i-1];
      r_addr   <= 15'(w_sb0.sy * SRC_W) + 15'(w_sb0.sx);
      r_gray_p <= gray8(prev_data);
      r_gray_c <= gray8(curr_data);
      r_motion <= enable & r_sb[2].de & (w_diff > thresh);
    end
  end

  always_comb begin
    w_hit     = r_motion & r_sb[3].tag;
    w_cnt_nx  = r_cnt;
    w_xmin_nx = r_xmin;
    w_xmax_nx = r_xmax;
    w_ymin_nx = r_ymin;
    w_ymax_nx = r_ymax;
    if (w_hit) begin
      if (r_cnt != CNT_MAX)      w_cnt_nx  = r_cnt + 15'd1;
      if (r_sb[3].sx < r_xmin)   w_xmin_nx = r_sb[3].sx;
      if (r_sb[3].sx > r_xmax)   w_xmax_nx = r_sb[3].sx;
      if (r_sb[3].sy < r_ymin)   w_ymin_nx = r_sb[3].sy;
      if (r_sb[3].sy > r_ymax)   w_ymax_nx = r_sb[3].sy;
    end
  end

  // Frame end latches the *next* accumulator values so its own hit is included.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_armed        <= 1'b0;
      r_cnt          <= '0;
      r_xmin         <= '1;
      r_xmax         <= '0;
      r_ymin         <= '1;
      r_ymax         <= '0;
      r_stats_valid  <= 1'b0;
      r_found        <= 1'b0;
      r_motion_count <= '0;
      r_box_x_min    <= '0;
      r_box_x_max    <= '0;
      r_box_y_min    <= '0;
      r_box_y_max    <= '0;
    end else begin
      r_stats_valid <= 1'b0;
      if (r_sb[3].first) r_armed <= 1'b1;
      if (r_sb[3].last) begin
        r_cnt  <= '0;
        r_xmin <= '1;
        r_xmax <= '0;
        r_ymin <= '1;
        r_ymax <= '0;
        if (r_armed) begin
          r_stats_valid  <= 1'b1;
          r_motion_count <= w_cnt_nx;
          r_found        <= (w_cnt_nx >= MIN_CNT);
          if (w_cnt_nx == '0) begin
            r_box_x_min <= '0;
            r_box_x_max <= '0;
            r_box_y_min <= '0;
            r_box_y_max <= '0;
          end else begin
            r_box_x_min <= w_xmin_nx;
            r_box_x_max <= w_xmax_nx;
            r_box_y_min <= w_ymin_nx;
            r_box_y_max <= w_ymax_nx;
          end
        end
      end else begin
        r_cnt  <= w_cnt_nx;
        r_xmin <= w_xmin_nx;
        r_xmax <= w_xmax_nx;
        r_ymin <= w_ymin_nx;
        r_ymax <= w_ymax_nx;
      end
    end
  end

  assign oe           = r_sb[0].de;
  assign rAddr        = r_addr;
  assign motion_px    = r_motion;
  assign motion_de    = r_sb[3].de;
  assign stats_valid  = r_stats_valid;
  assign motion_count = r_motion_count;
  assign box_x_min    = r_box_x_min;
  assign box_x_max    = r_box_x_max;
  assign box_y_min    = r_box_y_min;
  assign box_y_max    = r_box_y_max;
  assign motion_found = r_found;

endmodule

// File: tb/tb_frame_motion_detector.sv
// Bench for frame_motion_detector on a reduced 16x12 source raster with a
// frame-store model and a per-source-pixel reference of motion and statistics.
module tb_frame_motion_detector;

  localparam int SW = 16, SH = 12, SS = 2, MINP = 4;
  localparam int DW = SW << SS, DH = SH << SS;
  localparam int HT = DW + 6, VT = DH + 3;

  logic        clk = 1'b0, reset = 1'b1, enable = 1'b1, de = 1'b0;
  logic [9:0]  x_pixel = '0, y_pixel = '0;
  logic [7:0]  thresh = '0;
  logic        oe, motion_px, motion_de, stats_valid, motion_found;
  logic [14:0] rAddr, motion_count;
  logic [15:0] prev_data = '0, curr_data = '0;
  logic [7:0]  box_x_min, box_x_max;
  logic [6:0]  box_y_min, box_y_max;

  logic [15:0] prev_mem [SW*SH];
  logic [15:0] curr_mem [SW*SH];

  int n_assert = 0, n_fail = 0;
  int en_row0 = 0;
  bit armed_m = 0;
  int e_cnt = 0, e_xmin = 0, e_xmax = 0, e_ymin = 0, e_ymax = 0, e_found = 0;
  logic [1:0] mq[$];
  logic       sq[$];

  frame_motion_detector #(.SRC_W(SW), .SRC_H(SH), .SCALE_SHIFT(SS), .MIN_PIXELS(MINP)) dut (
    .clk(clk), .reset(reset), .enable(enable), .de(de), .x_pixel(x_pixel), .y_pixel(y_pixel),
    .thresh(thresh), .oe(oe), .rAddr(rAddr), .prev_data(prev_data), .curr_data(curr_data),
    .motion_px(motion_px), .motion_de(motion_de), .stats_valid(stats_valid),
    .motion_count(motion_count), .box_x_min(box_x_min), .box_x_max(box_x_max),
    .box_y_min(box_y_min), .box_y_max(box_y_max), .motion_found(motion_found));

  always #5 clk = ~clk;

  // Frame store: one-cycle read latency, column 0 reads as zero on both buffers.
  always @(posedge clk) begin
    if (oe) begin
      prev_data <= (int'(rAddr) % SW == 0) ? 16'h0000 : prev_mem[int'(rAddr)];
      curr_data <= (int'(rAddr) % SW == 0) ? 16'h0000 : curr_mem[int'(rAddr)];
    end
  end

  function automatic int gray(input logic [15:0] p);
    return 2 * int'(p[15:11]) + int'(p[10:5]) + 2 * int'(p[4:0]);
  endfunction

  function automatic bit src_motion(input int sx, input int sy);
    int d;
    if (sx == 0) return 1'b0;
    d = gray(curr_mem[sy*SW+sx]) - gray(prev_mem[sy*SW+sx]);
    if (d < 0) d = -d;
    return d > int'(thresh);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic compute_stats();
    e_cnt = 0; e_xmin = SW; e_xmax = -1; e_ymin = SH; e_ymax = -1;
    for (int sy = 0; sy < SH; sy++)
      for (int sx = 0; sx < SW; sx++)
        if ((sy << SS) >= en_row0 && src_motion(sx, sy)) begin
          e_cnt++;
          if (sx < e_xmin) e_xmin = sx;
          if (sx > e_xmax) e_xmax = sx;
          if (sy < e_ymin) e_ymin = sy;
          if (sy > e_ymax) e_ymax = sy;
        end
    if (e_cnt == 0) begin e_xmin = 0; e_xmax = 0; e_ymin = 0; e_ymax = 0; end
    e_found = (e_cnt >= MINP) ? 1 : 0;
  endtask

  task automatic step(input bit d, input int x, input int y);
    logic [1:0] em;
    logic       es;
    bit en, px, sv;
    @(negedge clk);
    em = mq.pop_front();
    es = sq.pop_front();
    check("motion_de_px", {motion_de, motion_px}, em);
    check("stats_valid", stats_valid, es);
    en = (y >= en_row0);
    px = d && en && src_motion(x >> SS, y >> SS);
    sv = 1'b0;
    if (d && x == 0 && y == 0) armed_m = 1'b1;
    if (d && x == DW-1 && y == DH-1 && armed_m) begin
      sv = 1'b1;
      compute_stats();
    end
    mq.push_back({d, px});
    sq.push_back(sv);
    de = d; x_pixel = 10'(x); y_pixel = 10'(y); enable = en;
  endtask

  task automatic run_rows(input int r0, input int r1);
    for (int y = r0; y < r1; y++)
      for (int x = 0; x < HT; x++)
        step(y < DH && x < DW, x, y);
  endtask

  task automatic check_stats(input string tag);
    check({tag, "_count"}, motion_count, e_cnt);
    check({tag, "_xmin"}, box_x_min, e_xmin);
    check({tag, "_xmax"}, box_x_max, e_xmax);
    check({tag, "_ymin"}, box_y_min, e_ymin);
    check({tag, "_ymax"}, box_y_max, e_ymax);
    check({tag, "_found"}, motion_found, e_found);
  endtask

  task automatic frame(input string tag);
    run_rows(0, VT);
    check_stats(tag);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; de = 1'b0; x_pixel = '0; y_pixel = '0;
    #1;
    check("rst_oe", oe, 0);
    check("rst_raddr", rAddr, 0);
    check("rst_mpx", motion_px, 0);
    check("rst_mde", motion_de, 0);
    check("rst_sv", stats_valid, 0);
    check("rst_count", motion_count, 0);
    check("rst_found", motion_found, 0);
    check("rst_box", {box_x_min, box_x_max, box_y_min, box_y_max}, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    armed_m = 1'b0;
    e_cnt = 0; e_xmin = 0; e_xmax = 0; e_ymin = 0; e_ymax = 0; e_found = 0;
    mq = {}; sq = {};
    repeat (4) mq.push_back(2'b00);
    repeat (5) sq.push_back(1'b0);
  endtask

  task automatic fill(input logic [15:0] p, input logic [15:0] c);
    for (int i = 0; i < SW*SH; i++) begin prev_mem[i] = p; curr_mem[i] = c; end
  endtask

  task automatic block(input int x0, input int x1, input int y0, input int y1,
                       input logic [15:0] p, input logic [15:0] c);
    for (int sy = y0; sy <= y1; sy++)
      for (int sx = x0; sx <= x1; sx++) begin
        prev_mem[sy*SW+sx] = p; curr_mem[sy*SW+sx] = c;
      end
  endtask

  initial begin
    do_reset();

    fill(16'h7BEF, 16'h7BEF); thresh = 8'd4;
    frame("identity");
    check("identity_count_const", motion_count, 0);

    fill(16'h0000, 16'h0000); block(4, 8, 3, 5, 16'h0000, 16'hFFFF); thresh = 8'd10;
    frame("block");
    check("block_count_const", motion_count, 15);
    check("block_box_const", {box_x_min, box_x_max, 1'b0, box_y_min, 1'b0, box_y_max}, {8'd4, 8'd8, 8'd3, 8'd5});

    fill(16'h0000, 16'h0000); block(0, 0, 5, 5, 16'h0000, 16'hFFFF);
    frame("col0");
    check("col0_count_const", motion_count, 0);
    fill(16'h0000, 16'h0000); block(1, 1, 5, 5, 16'h0000, 16'hFFFF);
    frame("col1");
    check("col1_count_const", motion_count, 1);

    fill(16'h0000, 16'h0000);
    block(2, 5, 2, 2, {5'd20, 6'd60, 5'd0}, {5'd20, 6'd60, 5'd10});
    thresh = 8'd20;
    frame("thr_eq");
    check("thr_eq_count_const", motion_count, 0);
    thresh = 8'd19;
    frame("thr_lt");
    check("thr_lt_count_const", motion_count, 4);

    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < SW*SH; i++) begin
        prev_mem[i] = 16'($urandom);
        curr_mem[i] = ($urandom_range(0, 3) == 0) ? 16'($urandom) : prev_mem[i];
      end
      thresh = 8'($urandom_range(0, 60));
      frame("random");
    end

    fill(16'h0000, 16'h0000); block(2, 6, 1, 8, 16'h0000, 16'hFFFF); thresh = 8'd10;
    run_rows(0, 25);
    do_reset();
    run_rows(26, VT);
    check_stats("partial");
    frame("after_rst");
    check("after_rst_count_const", motion_count, 40);

    fill(16'h0000, 16'h0000); block(3, 10, 2, 9, 16'h0000, 16'hFFFF);
    en_row0 = 24;
    frame("enable");
    check("enable_count_const", motion_count, 32);
    en_row0 = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/frame_motion_detector.md
Name: frame_motion_detector

Overview:
- Downstream consumer of the double-buffered 160x120 RGB565 frame store, in the VGA pixel-clock domain.
- Generates the store's read address and oe from the display raster (640x480, 4x upscale).
- Compares each current-frame pixel against the previous-frame pixel in grayscale, emits a per-pixel motion flag aligned to the raster, and produces per-frame statistics: motion pixel count and bounding box in source coordinates.

Parameters:
- SRC_W, 160, source frame width in pixels
- SRC_H, 120, source frame height in pixels
- SCALE_SHIFT, 2, log2 of the display-to-source upscale factor (display 640x480)
- MIN_PIXELS, 16, minimum per-frame motion count that asserts motion_found

Ports:
- clk  in  1  pixel clock, same clock as the frame store read side
- reset  in  1  asynchronous, active-high reset
- enable  in  1  1 = detection and accumulation active; 0 = motion_px forced 0, no accumulation
- de  in  1  display active-area flag
- x_pixel  in  10  display column 0..639
- y_pixel  in  10  display row 0..479
- thresh  in  8  grayscale difference threshold
- oe  out  1  frame store read enable
- rAddr  out  15  frame store read address
- prev_data  in  16  RGB565 pixel from previous frame, valid 1 cycle after rAddr/oe
- curr_data  in  16  RGB565 pixel from current frame, same timing
- motion_px  out  1  per-pixel motion flag, aligned with motion_de
- motion_de  out  1  de delayed to match motion_px
- stats_valid  out  1  one-cycle pulse when frame statistics update
- motion_count  out  15  motion source pixels in the last complete frame
- box_x_min  out  8  bounding box left edge, source column
- box_x_max  out  8  bounding box right edge, source column
- box_y_min  out  7  bounding box top edge, source row
- box_y_max  out  7  bounding box bottom edge, source row
- motion_found  out  1  motion_count >= MIN_PIXELS for the last frame

Behaviour:
- Reset: all outputs 0; all pipeline registers, accumulators and the armed flag cleared.
- Stage 0 (cycle N): sample de, x_pixel, y_pixel.
- Stage 1 (N+1): rAddr = (y>>SCALE_SHIFT)*SRC_W + (x>>SCALE_SHIFT), registered; oe = registered de.
- Stage 2 (N+2): prev_data/curr_data are valid from the store.
- Stage 3 (N+3): gray8 = {R5,0} + G6 + {B5,0} for both pixels, zero-extended to 8 bits (max 187).
- Stage 4 (N+4): diff = |gray_curr - gray_prev|; motion_px = enable & de_d & (diff > thresh), strictly greater; motion_de = de_d.
- Latency from x/y/de to motion_px is 4 cycles. Side-band (de, source x/y, first/last flags) is delayed alongside the data.
- The store returns 0 for source column 0 on both buffers, so diff = 0 and motion_px = 0 in column 0. This is required, not a defect.
- Sample tag: each source pixel counts once, using only display samples with x[1:0]==0 and y[1:0]==0.
- Accumulation when tag & motion_px: cnt++ (saturates at 19200), update min/max of source x and y.
- Accumulator init/clear: cnt = 0, xmin = 255, xmax = 0, ymin = 127, ymax = 0.
- Armed flag: set when the (x=0, y=0, de=1) sample reaches stage 4; cleared by reset.
- Frame end: the (x=639, y=479, de=1) sample reaches stage 4.
  - If armed, latch cnt and box into the outputs, set motion_found = (cnt >= MIN_PIXELS), pulse stats_valid for 1 cycle.
  - If armed and cnt = 0, all box outputs are 0.
  - Accumulators clear in the same cycle, regardless of armed.
  - A motion pixel on the frame-end sample itself is included in the latched result.
- Reset mid-frame: the partial frame is discarded. The first stats_valid follows the first complete frame after reset.
- enable=0 mid-frame: accumulation pauses but the frame still reports at frame end. Outputs hold between stats_valid pulses.
- Blanking (de=0): oe = 0, motion_px = 0, no accumulation. rAddr still updates and is don't-care.

Test Plan:
- Identity frames (prev = curr = 0x7BEF everywhere), thresh = 4, full raster -> motion_px never 1. stats_valid pulses once at frame end with count 0, box all 0, motion_found 0.
- prev = 0x0000, curr = 0xFFFF in source block x 40..49, y 30..34, thresh = 10 -> motion_count 50, box 40/49/30/34, motion_found 1. motion_px high exactly for display x 160..199, y 120..139, 4 cycles after input.
- Single differing pixel at source (0, 10) -> no motion (column 0 forced 0). Same pixel at (1, 10) -> count 1, box 1/1/10/10, motion_found 0.
- diff exactly equal to thresh (gray 100 vs 120, thresh = 20) -> no motion. thresh = 19 -> motion.
- Assert reset at display y = 200, release, run 1.5 frames -> no stats_valid for the partial frame. The first pulse comes at the end of the next full frame, with correct counts.
- enable = 0 for rows 0..239 with a motion region spanning rows 200..300 (display) -> count covers source rows 60..75 only. motion_px is 0 while enable = 0.
